// File: rtl/irq_pend_ctrl_8_pkg.sv
// Shared definitions for the irq_pend_ctrl_8 interrupt front end.
// Request count, code width, handshake state encodings and the code-to-one-hot helper.
package irq_pend_ctrl_8_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TOUT = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] code_onehot(input logic [CODE_W-1:0] code);
    code_onehot       = '0;
    code_onehot[code] = 1'b1;
  endfunction

endpackage

// File: rtl/irq_pend_ctrl_8_pri_enc.sv
// Combinational 8-to-3 priority encoder, bit 7 highest; an all-zero input encodes as 0.
module pri_enc_8x3_comb
  import irq_pend_ctrl_8_pkg::*;
(
  input  logic [N_REQ-1:0]  req_vec,
  output logic [CODE_W-1:0] code
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    code = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_vec[i]) code = CODE_W'(i);
    end
  end

endmodule

// File: rtl/irq_pend_ctrl_8.sv
// Interrupt front end: captures requests into a pending register, arbitrates enabled bits,
// presents one registered code per valid/ack handshake and tracks overflow/timeout flags.
module irq_pend_ctrl_8
  import irq_pend_ctrl_8_pkg::*;
#(
  parameter int unsigned EDGE_MODE   = 1,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  mask,
  input  logic              irq_ack,
  input  logic              flag_clr,
  output logic              irq_valid,
  output logic [CODE_W-1:0] irq_code,
  output logic [N_REQ-1:0]  pending,
  output logic              overflow,
  output logic              timeout
);

  // A zero timeout would give a zero-width timer; keep one bit so the logic stays legal.
  localparam int unsigned TW     = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int unsigned T_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

  state_e            state, state_nxt;
  logic [N_REQ-1:0]  req_q, rise, set_vec, clr_vec, pending_nxt, arb_vec;
  logic [CODE_W-1:0] enc_code, code_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic              valid_nxt, ack_ok, tout_hit, ovf_hit;

  assign arb_vec = pending & mask;

  pri_enc_8x3_comb u_enc (
    .req_vec (arb_vec),
    .code    (enc_code)
  );

  assign rise        = req & ~req_q;
  assign set_vec     = (EDGE_MODE != 0) ? rise : req;
  assign ack_ok      = (state == BUSY) && irq_valid && irq_ack;
  assign clr_vec     = ack_ok ? code_onehot(irq_code) : '0;
  assign pending_nxt = (pending & ~clr_vec) | set_vec;
  assign ovf_hit     = (EDGE_MODE != 0) && (|(rise & pending & ~clr_vec));
  assign tout_hit    = (ACK_TIMEOUT != 0) && (state == BUSY) && !ack_ok &&
                       (timer == TW'(T_LAST));

  always_comb begin
    state_nxt = state;
    valid_nxt = irq_valid;
    code_nxt  = irq_code;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (|arb_vec) begin
          state_nxt = BUSY;
          valid_nxt = 1'b1;
          code_nxt  = enc_code;
          timer_nxt = '0;
        end
      end
      BUSY: begin
        if (ack_ok) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end else if (tout_hit) begin
          state_nxt = TOUT;
          valid_nxt = 1'b0;
        end else if (timer != '1) begin
          timer_nxt = timer + TW'(1);
        end
      end
      TOUT: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      pending   <= '0;
      irq_valid <= 1'b0;
      irq_code  <= '0;
      timer     <= '0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_q     <= req;
      pending   <= pending_nxt;
      irq_valid <= valid_nxt;
      irq_code  <= code_nxt;
      timer     <= timer_nxt;
      // Sticky flags: a new event in the same cycle beats flag_clr.
      if (ovf_hit)       overflow <= 1'b1;
      else if (flag_clr) overflow <= 1'b0;
      if (tout_hit)      timeout  <= 1'b1;
      else if (flag_clr) timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_irq_pend_ctrl_8.sv
// Bench for irq_pend_ctrl_8: edge-mode instance with a short ack timeout and a level-mode
// instance without timeout; grant codes are scoreboarded, flags and pending checked inline.
module tb_irq_pend_ctrl_8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_e, ack_e, fclr_e, v_e, ovf_e, to_e;
  logic [7:0] req_e, mask_e, pend_e;
  logic [2:0] code_e;

  logic       rst_l, ack_l, fclr_l, v_l, ovf_l, to_l;
  logic [7:0] req_l, mask_l, pend_l;
  logic [2:0] code_l;

  irq_pend_ctrl_8 #(.EDGE_MODE(1), .ACK_TIMEOUT(4)) u_edge (
    .clk(clk), .rst(rst_e), .req(req_e), .mask(mask_e), .irq_ack(ack_e),
    .flag_clr(fclr_e), .irq_valid(v_e), .irq_code(code_e), .pending(pend_e),
    .overflow(ovf_e), .timeout(to_e)
  );

  irq_pend_ctrl_8 #(.EDGE_MODE(0), .ACK_TIMEOUT(0)) u_level (
    .clk(clk), .rst(rst_l), .req(req_l), .mask(mask_l), .irq_ack(ack_l),
    .flag_clr(fclr_l), .irq_valid(v_l), .irq_code(code_l), .pending(pend_l),
    .overflow(ovf_l), .timeout(to_l)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_e[$];
  logic [2:0] exp_l[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each new assertion of irq_valid is one grant and consumes one expected code.
  logic pv_e = 1'b0;
  logic pv_l = 1'b0;
  always @(negedge clk) begin
    if (v_e && !pv_e) begin
      if (exp_e.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_e: unexpected grant code %0d expected none", code_e);
      end else check("grant_e", code_e, exp_e.pop_front());
    end
    pv_e = v_e;
  end
  always @(negedge clk) begin
    if (v_l && !pv_l) begin
      if (exp_l.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_l: unexpected grant code %0d expected none", code_l);
      end else check("grant_l", code_l, exp_l.pop_front());
    end
    pv_l = v_l;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_v_e(input string name);
    int n = 0;
    while (!v_e && n < 20) begin tick(); n++; end
    check(name, v_e, 1);
  endtask

  task automatic wait_v_l(input string name);
    int n = 0;
    while (!v_l && n < 20) begin tick(); n++; end
    check(name, v_l, 1);
  endtask

  task automatic do_ack_e();
    wait_v_e("ack_wait_e");
    ack_e = 1'b1; tick(); ack_e = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_e = 1; ack_e = 0; fclr_e = 0; req_e = '0; mask_e = 8'hFF;
    rst_l = 1; ack_l = 0; fclr_l = 0; req_l = '0; mask_l = 8'hFF;
    tick(); tick();
    check("rst_valid", v_e, 0);
    check("rst_code", code_e, 0);
    check("rst_pend", pend_e, 0);
    check("rst_ovf", ovf_e, 0);
    check("rst_tout", to_e, 0);
    check("rst_valid_l", v_l, 0);
    rst_e = 0; rst_l = 0;
    tick();

    // Two requests at once: code 5 then code 2.
    req_e = 8'h24; exp_e.push_back(3'd5); exp_e.push_back(3'd2);
    tick();
    check("t1_pend", pend_e, 8'h24);
    check("t1_valid_k", v_e, 0);
    tick();
    check("t1_valid_k1", v_e, 1);
    ack_e = 1; tick(); ack_e = 0;
    check("t1_pend_ack", pend_e, 8'h04);
    check("t1_valid_ack", v_e, 0);
    do_ack_e();
    check("t1_pend_empty", pend_e, 0);
    tick(); tick();
    check("t1_idle", v_e, 0);
    req_e = '0; tick();

    // Higher priority arriving while BUSY does not preempt.
    req_e = 8'h04; exp_e.push_back(3'd2); exp_e.push_back(3'd7);
    wait_v_e("t2_grant");
    req_e = 8'h84; tick(); tick();
    check("t2_frozen", code_e, 2);
    do_ack_e();
    do_ack_e();
    req_e = '0; tick();

    // Masked bit stays pending until enabled.
    mask_e = 8'h7F; req_e = 8'h82; exp_e.push_back(3'd1); exp_e.push_back(3'd7);
    do_ack_e();
    check("t3_pend7", pend_e, 8'h80);
    tick(); tick();
    check("t3_masked_idle", v_e, 0);
    mask_e = 8'hFF;
    do_ack_e();
    req_e = '0; tick();
    check("t3_pend_empty", pend_e, 0);

    // Overflow on second rise of a pending bit; single grant.
    req_e = 8'h08; exp_e.push_back(3'd3);
    tick();
    req_e = '0; tick();
    req_e = 8'h08; tick();
    check("t4_ovf", ovf_e, 1);
    req_e = '0;
    do_ack_e();
    check("t4_ovf_sticky", ovf_e, 1);
    check("t4_pend", pend_e, 0);
    fclr_e = 1; tick(); fclr_e = 0;
    check("t4_ovf_clr", ovf_e, 0);
    tick(); tick();
    check("t4_single_grant", v_e, 0);

    // Rise coinciding with ack of the same bit: set wins, no overflow.
    req_e = 8'h08; exp_e.push_back(3'd3); exp_e.push_back(3'd3);
    tick();
    req_e = '0; tick();
    check("t4b_valid", v_e, 1);
    req_e = 8'h08; ack_e = 1; tick(); ack_e = 0;
    check("t4b_pend", pend_e, 8'h08);
    check("t4b_no_ovf", ovf_e, 0);
    check("t4b_valid_drop", v_e, 0);
    do_ack_e();
    req_e = '0; tick();

    // Ack timeout: valid high 4 cycles, 2 low, regrant of the retained bit.
    req_e = 8'h10; exp_e.push_back(3'd4); exp_e.push_back(3'd4);
    wait_v_e("t5_grant");
    n = 0;
    while (v_e && n < 20) begin n++; tick(); end
    check("t5_high_cycles", n, 4);
    check("t5_tout", to_e, 1);
    check("t5_pend_kept", pend_e, 8'h10);
    n = 0;
    while (!v_e && n < 20) begin n++; tick(); end
    check("t5_low_cycles", n, 2);
    do_ack_e();
    fclr_e = 1; tick(); fclr_e = 0;
    check("t5_tout_clr", to_e, 0);
    req_e = '0; tick();

    // Reset mid-handshake, with req held high through reset.
    req_e = 8'h40; exp_e.push_back(3'd6);
    wait_v_e("t6_grant");
    rst_e = 1; tick();
    check("t6_rst_valid", v_e, 0);
    check("t6_rst_code", code_e, 0);
    check("t6_rst_pend", pend_e, 0);
    tick();
    exp_e.push_back(3'd6);
    rst_e = 0; tick();
    check("t6_rise_after_rst", pend_e, 8'h40);
    do_ack_e();
    req_e = '0; tick();

    // Level mode, no timeout: held indefinitely, then regrant every 2 cycles.
    req_l = 8'h10; exp_l.push_back(3'd4);
    wait_v_l("l_grant");
    repeat (30) tick();
    check("l_held_valid", v_l, 1);
    check("l_held_code", code_l, 4);
    check("l_no_tout", to_l, 0);
    ack_l = 1; tick();
    check("l_pend_reset", pend_l, 8'h10);
    check("l_valid_drop", v_l, 0);
    check("l_no_ovf", ovf_l, 0);
    repeat (4) exp_l.push_back(3'd4);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("l_alt_valid", v_l, (i % 2 == 0) ? 1 : 0);
      check("l_alt_pend", pend_l, 8'h10);
    end
    req_l = '0; tick();
    check("l_last_grant", v_l, 1);
    tick();
    check("l_last_ack", v_l, 0);
    check("l_pend_empty", pend_l, 0);
    tick(); tick();
    check("l_idle", v_l, 0);
    ack_l = 0;

    tick(); tick(); tick();
    check("queue_e_empty", exp_e.size(), 0);
    check("queue_l_empty", exp_l.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
